// File: rtl/counter_ctrl.sv
// counter_ctrl: sequencing controller for an N-bit up-counter.
// Loads a terminal limit and a clock prescale on start, then counts from 0 to
// the limit, advancing once every (prescale+1) clocks. Supports one-shot and
// periodic (auto-reload) modes, pause/resume, stop and restart, and emits a
// one-cycle done pulse on each terminal count.
//
// Ports:
//   clk      - system clock, rising edge
//   clear    - asynchronous active-high reset
//   start    - latch limit/prescale/periodic, zero count, enter RUN
//   stop     - abort to IDLE, count zeroed (highest priority)
//   pause    - level; freezes count and prescaler while high
//   periodic - 1 = auto-reload at terminal, 0 = one-shot (latched on start)
//   limit    - terminal count value (latched on start)
//   prescale - tick divider (latched on start)
//   count    - current count value (registered)
//   busy     - high in RUN and HOLD (registered)
//   done     - one-cycle pulse following the terminal tick (registered)
module counter_ctrl #(
  parameter int N          = 6,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic                  periodic,
  input  logic [N-1:0]          limit,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [N-1:0]          count,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [N-1:0]          r_count;
  logic [PRESCALE_W-1:0] r_presc;
  logic [N-1:0]          r_limit;
  logic [PRESCALE_W-1:0] r_prescale;
  logic                  r_periodic;
  logic                  r_busy;
  logic                  r_done;

  logic w_tick;
  logic w_at_limit;

  assign w_tick     = (r_presc == r_prescale);
  assign w_at_limit = (r_count == r_limit);

  assign count = r_count;
  assign busy  = r_busy;
  assign done  = r_done;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_presc    <= '0;
      r_limit    <= '0;
      r_prescale <= '0;
      r_periodic <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (stop) begin
        r_state <= S_IDLE;
        r_count <= '0;
        r_presc <= '0;
        r_busy  <= 1'b0;
      end else if (start) begin
        r_limit    <= limit;
        r_prescale <= prescale;
        r_periodic <= periodic;
        r_count    <= '0;
        r_presc    <= '0;
        r_state    <= S_RUN;
        r_busy     <= 1'b1;
      end else begin
        case (r_state)
          // HOLD releasing pause takes the counting step on the same edge it
          // returns to RUN, so a pause of P sampled cycles delays done by P.
          S_RUN, S_HOLD: begin
            r_busy <= 1'b1;
            if (pause) begin
              r_state <= S_HOLD;
            end else begin
              r_state <= S_RUN;
              if (w_tick) begin
                r_presc <= '0;
                if (w_at_limit) begin
                  r_done <= 1'b1;
                  if (r_periodic) begin
                    r_count <= '0;
                  end else begin
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                  end
                end else begin
                  r_count <= r_count + 1'b1;
                end
              end else begin
                r_presc <= r_presc + 1'b1;
              end
            end
          end
          default: begin
            // IDLE and DONE hold count until start or stop
            r_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
